alu_share_arbiter: RTL and testbench

//  Shares one 32-bit ALU between two requesters (e.g. main datapath and branch/address unit).
//  Per-requester valid/ready request ports; round-robin grant when both request.
//  One registered result slot with valid/ready backpressure.
//  Per-requester completed-op counters for performance monitoring.

---
 rtl/alu_share_arbiter_pkg.sv | 16 +
 rtl/alu_share_arbiter_if.sv | 50 +++++
 rtl/alu_share_arbiter_alu.sv | 36 +++
 rtl/alu_share_arbiter.sv | 126 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the two-requester ALU arbiter: ALU control codes and
// default widths used by the interface, the ALU and the arbiter top.
package alu_share_arbiter_pkg;

    localparam int W_DEF     = 32;
    localparam int CTR_W_DEF = 4;
    localparam int CNT_W_DEF = 16;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Bundle of the two request ports, the response slot and the completion
// counters. The slave side is the arbiter; the master side drives requests
// and consumes responses.
interface alu_share_if #(
    parameter int W     = 32,
    parameter int CTR_W = 4,
    parameter int CNT_W = 16
);
    logic             req0_valid;
    logic [W-1:0]     req0_a;
    logic [W-1:0]     req0_b;
    logic [CTR_W-1:0] req0_ctr;
    logic             req0_ready;

    logic             req1_valid;
    logic [W-1:0]     req1_a;
    logic [W-1:0]     req1_b;
    logic [CTR_W-1:0] req1_ctr;
    logic             req1_ready;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [W-1:0]     rsp_res;
    logic             rsp_zero;

    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctr,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctr,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_res, rsp_zero,
        input  rsp_ready,
        output cnt0, cnt1
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_ctr,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_ctr,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_res, rsp_zero,
        output rsp_ready,
        input  cnt0, cnt1
    );

endinterface

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU shared by both requesters. Unknown control codes
// yield zero; SLT reports the sign of the wrapped difference (overflow ignored).
module alu_share_arbiter_alu
    import alu_share_arbiter_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CTR_W = CTR_W_DEF
) (
    input  logic [W-1:0]     input1,
    input  logic [W-1:0]     input2,
    input  logic [CTR_W-1:0] aluCtr,
    output logic [W-1:0]     aluRes,
    output logic             zero
);

    logic [W-1:0] diff_s;

    assign diff_s = input1 - input2;

    // Select the operation result from the control code.
    always_comb begin
        aluRes = {W{1'b0}};
        case (aluCtr)
            ALU_AND: aluRes = input1 & input2;
            ALU_OR:  aluRes = input1 | input2;
            ALU_ADD: aluRes = input1 + input2;
            ALU_SUB: aluRes = diff_s;
            ALU_SLT: aluRes = {{(W-1){1'b0}}, diff_s[W-1]};
            ALU_NOR: aluRes = ~(input1 | input2);
            default: aluRes = {W{1'b0}};
        endcase
    end

    assign zero = (aluRes == {W{1'b0}});

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, with a single
// registered result slot (valid/ready) and per-requester completion counters.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CTR_W = CTR_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    alu_share_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             slot_free_s;
    logic             grant0_s;
    logic             grant1_s;
    logic             grant_s;
    logic [W-1:0]     op_a_s;
    logic [W-1:0]     op_b_s;
    logic [CTR_W-1:0] op_ctr_s;
    logic [W-1:0]     alu_res_s;
    logic             alu_zero_s;
    logic             xfer_s;

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q,    rsp_id_d;
    logic [W-1:0]     rsp_res_q,   rsp_res_d;
    logic             rsp_zero_q,  rsp_zero_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    // A slot may be refilled in the same cycle it drains.
    assign slot_free_s = !rsp_valid_q || bus.rsp_ready;
    assign xfer_s      = rsp_valid_q && bus.rsp_ready;

    // Tie goes to the requester that did not win last; a lone requester always wins.
    assign grant0_s = !reset && slot_free_s && bus.req0_valid &&
                      (!bus.req1_valid || last_grant_q);
    assign grant1_s = !reset && slot_free_s && bus.req1_valid &&
                      (!bus.req0_valid || !last_grant_q);
    assign grant_s  = grant0_s || grant1_s;

    assign bus.req0_ready = grant0_s;
    assign bus.req1_ready = grant1_s;

    assign op_a_s   = grant1_s ? bus.req1_a   : bus.req0_a;
    assign op_b_s   = grant1_s ? bus.req1_b   : bus.req0_b;
    assign op_ctr_s = grant1_s ? bus.req1_ctr : bus.req0_ctr;

    alu_share_arbiter_alu #(
        .W     (W),
        .CTR_W (CTR_W)
    ) u_alu (
        .input1 (op_a_s),
        .input2 (op_b_s),
        .aluCtr (op_ctr_s),
        .aluRes (alu_res_s),
        .zero   (alu_zero_s)
    );

    // Next state of the result slot and the round-robin pointer.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_res_d    = rsp_res_q;
        rsp_zero_d   = rsp_zero_q;
        last_grant_d = last_grant_q;
        if (grant_s) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = grant1_s;
            rsp_res_d    = alu_res_s;
            rsp_zero_d   = alu_zero_s;
            last_grant_d = grant1_s;
        end else if (xfer_s) begin
            rsp_valid_d  = 1'b0;
        end else begin
            rsp_valid_d  = rsp_valid_q;
        end
    end

    // Next state of the delivered-response counters (wrap naturally).
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (xfer_s && !rsp_id_q) begin
            cnt0_d = cnt0_q + CNT_ONE;
        end else if (xfer_s && rsp_id_q) begin
            cnt1_d = cnt1_q + CNT_ONE;
        end else begin
            cnt0_d = cnt0_q;
        end
    end

    // State registers; reset discards any in-flight result and leaves req0 first in line.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_res_q    <= {W{1'b0}};
            rsp_zero_q   <= 1'b0;
            last_grant_q <= 1'b1;
            cnt0_q       <= {CNT_W{1'b0}};
            cnt1_q       <= {CNT_W{1'b0}};
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_res_q    <= rsp_res_d;
            rsp_zero_q   <= rsp_zero_d;
            last_grant_q <= last_grant_d;
            cnt0_q       <= cnt0_d;
            cnt1_q       <= cnt1_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_res   = rsp_res_q;
    assign bus.rsp_zero  = rsp_zero_q;
    assign bus.cnt0      = cnt0_q;
    assign bus.cnt1      = cnt1_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a reference model predicts grants,
// results (via a scoreboard queue) and counters; checks happen at the falling edge.
module tb_alu_share_arbiter;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_NOR = 4'b1100;
    localparam logic [3:0] C_BAD = 4'b1111;

    typedef struct packed {
        logic        id;
        logic [31:0] res;
        logic        zero;
    } exp_t;

    logic clk;
    logic reset;

    alu_share_if #(.W(32), .CTR_W(4), .CNT_W(4)) bus ();

    alu_share_arbiter #(.W(32), .CTR_W(4), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int nvec = 0;
    int nerr = 0;

    exp_t        exp_q[$];
    logic        m_last;
    logic [3:0]  m_cnt0;
    logic [3:0]  m_cnt1;
    logic        m_id;
    logic [31:0] m_res;
    logic        m_zero;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
        logic [31:0] d;
        d = a - b;
        case (c)
            C_AND:   return a & b;
            C_OR:    return a | b;
            C_ADD:   return a + b;
            C_SUB:   return d;
            C_SLT:   return {31'd0, d[31]};
            C_NOR:   return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_last = 1'b1;
        m_cnt0 = 4'd0;
        m_cnt1 = 4'd0;
        m_id   = 1'b0;
        m_res  = 32'd0;
        m_zero = 1'b0;
    endtask

    task automatic set0(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c);
        bus.req0_valid = v;
        bus.req0_a     = a;
        bus.req0_b     = b;
        bus.req0_ctr   = c;
    endtask

    task automatic set1(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c);
        bus.req1_valid = v;
        bus.req1_a     = a;
        bus.req1_b     = b;
        bus.req1_ctr   = c;
    endtask

    // One clock: check DUT against the model at negedge, advance model, return at posedge+1.
    task automatic cycle();
        logic free, g0, g1;
        exp_t e;
        @(negedge clk);
        free = (exp_q.size() == 0) || (bus.rsp_ready === 1'b1);
        g0 = !reset && free && bus.req0_valid && (!bus.req1_valid || m_last);
        g1 = !reset && free && bus.req1_valid && (!bus.req0_valid || !m_last);
        chk("req0_ready", 32'(bus.req0_ready), 32'(g0));
        chk("req1_ready", 32'(bus.req1_ready), 32'(g1));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) e = exp_q[0];
        else e = '{id: m_id, res: m_res, zero: m_zero};
        chk("rsp_id", 32'(bus.rsp_id), 32'(e.id));
        chk("rsp_res", bus.rsp_res, e.res);
        chk("rsp_zero", 32'(bus.rsp_zero), 32'(e.zero));
        chk("cnt0", 32'(bus.cnt0), 32'(m_cnt0));
        chk("cnt1", 32'(bus.cnt1), 32'(m_cnt1));
        if (reset) begin
            model_reset();
        end else begin
            if (exp_q.size() != 0 && bus.rsp_ready) begin
                e = exp_q.pop_front();
                if (e.id) m_cnt1 = m_cnt1 + 4'd1;
                else m_cnt0 = m_cnt0 + 4'd1;
            end
            if (g0 || g1) begin
                if (g1) e.res = ref_alu(bus.req1_a, bus.req1_b, bus.req1_ctr);
                else e.res = ref_alu(bus.req0_a, bus.req0_b, bus.req0_ctr);
                e.id   = g1;
                e.zero = (e.res == 32'd0);
                exp_q.push_back(e);
                m_id   = e.id;
                m_res  = e.res;
                m_zero = e.zero;
                m_last = g1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.rsp_ready = 1'b0;
        set0(1'b0, 32'd0, 32'd0, C_AND);
        set1(1'b0, 32'd0, 32'd0, C_AND);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // Idle after reset.
        repeat (2) cycle();

        // Single ADD from req0.
        bus.rsp_ready = 1'b1;
        set0(1'b1, 32'd5, 32'd7, C_ADD);
        cycle();
        set0(1'b0, 32'd0, 32'd0, C_AND);
        chk("add_res", bus.rsp_res, 32'd12);
        chk("add_id", 32'(bus.rsp_id), 32'd0);
        cycle();
        chk("add_cnt0", 32'(bus.cnt0), 32'd1);

        // Fresh round-robin: both requesters valid for 4 cycles.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        set0(1'b1, 32'd3, 32'd3, C_SUB);
        set1(1'b1, 32'd2, 32'd9, C_SLT);
        cycle();
        chk("rr0_id", 32'(bus.rsp_id), 32'd0);
        chk("rr0_zero", 32'(bus.rsp_zero), 32'd1);
        cycle();
        chk("rr1_id", 32'(bus.rsp_id), 32'd1);
        chk("rr1_res", bus.rsp_res, 32'd1);
        repeat (2) cycle();
        set0(1'b0, 32'd0, 32'd0, C_AND);
        set1(1'b0, 32'd0, 32'd0, C_AND);
        cycle();

        // Backpressure: slot full, req1 OR waits 3 cycles, then accepted on release.
        bus.rsp_ready = 1'b0;
        set0(1'b1, 32'h0000_0F0F, 32'h0000_00FF, C_AND);
        cycle();
        set0(1'b0, 32'd0, 32'd0, C_AND);
        set1(1'b1, 32'h0000_0010, 32'h0000_0001, C_OR);
        repeat (3) cycle();
        chk("bp_hold_res", bus.rsp_res, 32'h0000_000F);
        bus.rsp_ready = 1'b1;
        cycle();
        set1(1'b0, 32'd0, 32'd0, C_AND);
        chk("bp_or_res", bus.rsp_res, 32'h0000_0011);
        cycle();

        // Undefined code and NOR corner.
        set0(1'b1, 32'd5, 32'd3, C_BAD);
        cycle();
        chk("bad_res", bus.rsp_res, 32'd0);
        chk("bad_zero", 32'(bus.rsp_zero), 32'd1);
        set0(1'b1, 32'd0, 32'd0, C_NOR);
        cycle();
        chk("nor_res", bus.rsp_res, 32'hFFFF_FFFF);
        set0(1'b0, 32'd0, 32'd0, C_AND);
        cycle();
        cycle();

        // Counter wrap: 16 back-to-back req0 transfers into a 4-bit counter.
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set0(1'b1, 32'(i * 3), 32'(i), (i % 2 == 0) ? C_ADD : C_SUB);
            cycle();
        end
        set0(1'b0, 32'd0, 32'd0, C_AND);
        cycle();
        chk("wrap_cnt0", 32'(bus.cnt0), 32'd0);

        // Reset while a result is pending: dropped, not counted.
        set1(1'b1, 32'd1, 32'd1, C_ADD);
        cycle();
        set1(1'b0, 32'd0, 32'd0, C_AND);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_cnt1", 32'(bus.cnt1), 32'd0);
        repeat (2) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
